pipeline_hazard_controller: RTL and testbench
=============================================

// Module: pipeline_hazard_controller
// PURPOSE
// - Drives the enable/bubble/flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline_register
//   stages and the PC enable: the control end of the two-phase stage-register interface.
// - Detects load-use hazards (ID vs EX), taken-branch flushes (resolved in EX), data-memory waits
//   and halt; sequences multi-cycle stalls/flushes with a small FSM; counts lost cycles.
// PARAMETERS
// - REG_ADDR_W     5   register index width
// - LOAD_STALL_CYC 1   stall cycles per load-use hazard (2 when no MEM->EX forwarding); >=1
// - FLUSH_CYC      2   bubble cycles per taken branch; >=1
// - CNT_W          16  stall_count width
// PORTS
// - clk            in   1           clock, rising edge
// - reset          in   1           asynchronous, active-low
// - id_rs1, id_rs2 in   REG_ADDR_W  source regs of instruction in ID
// - id_use_rs1/2   in   1           ID instruction actually reads rs1/rs2
// - ex_rd          in   REG_ADDR_W  dest reg of instruction in EX
// - ex_mem_read    in   1           EX instruction is a load
// - ex_branch_taken in  1           branch/jump in EX resolved taken
// - mem_busy       in   1           data memory not ready this cycle
// - halt_req       in   1           halt instruction reached WB
// - pc_en          out  1           PC update enable
// - en_if_id, en_id_ex, en_ex_mem, en_mem_wb  out 1 each  stage-register enables
// - flush_if_id    out  1           replace IF/ID input with NOP
// - bubble_id_ex   out  1           replace ID/EX input with NOP
// - state          out  2           FSM state (RUN=0, STALL=1, FLUSH=2, HALT=3)
// - stall_count    out  CNT_W       cycles with pc_en=0 or a bubble/flush, outside HALT
// BEHAVIOUR
// - Reset (async, reset=0): state=RUN, internal down-counter=0, stall_count=0. Control outputs are
//   combinational from state+inputs; with idle inputs in RUN: all enables=1, flush/bubble=0.
// - load_use = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
// - Priority in the same cycle: mem_busy > HALT > ex_branch_taken > load_use > normal.
// - mem_busy=1 (any state): all five enables=0, flush/bubble=0; FSM, down-counter and stall_count
//   hold. Resumes exactly where it was when mem_busy falls.
// - RUN, halt_req=1: enables all 0 this cycle; next state HALT.
// - RUN, ex_branch_taken=1: flush_if_id=1, bubble_id_ex=1, all enables=1; if FLUSH_CYC>1 load
//   counter=FLUSH_CYC-1, next FLUSH; else stay RUN. load_use ignored that cycle (ID is squashed).
// - RUN, load_use=1: pc_en=0, en_if_id=0, bubble_id_ex=1, en_id_ex/ex_mem/mem_wb=1; if
//   LOAD_STALL_CYC>1 load counter=LOAD_STALL_CYC-1, next STALL; else stay RUN.
// - STALL: same outputs as load-use; counter decrements; when counter==1 next state RUN.
//   Hazard/branch inputs ignored (EX holds a bubble).
// - FLUSH: flush_if_id=1, bubble_id_ex=1, enables=1; counter decrements; counter==1 -> RUN. Inputs
//   other than mem_busy ignored.
// - HALT: all enables 0, flush/bubble 0; terminal until reset; stall_count holds.
// - stall_count: +1 at each posedge where (pc_en=0 | flush_if_id | bubble_id_ex) and state!=HALT
//   and mem_busy=0; saturates at 2^CNT_W-1, never wraps.
// - Reset asserted mid-STALL/FLUSH/HALT: immediate return to RUN, counters cleared.
// TESTING
// - Load x5 in EX, ID reads rs1=x5, use=1 -> pc_en=0, en_if_id=0, bubble_id_ex=1 one cycle; stall_count=1.
// - Same but ex_rd=0 -> no stall, all enables 1, stall_count stays 0.
// - ex_branch_taken=1 with FLUSH_CYC=2 -> flush+bubble for 2 cycles, state RUN->FLUSH->RUN, stall_count=2.
// - mem_busy=1 for 3 cycles during FLUSH -> all enables 0, state/counter frozen, then 1 flush cycle resumes.
// - Branch and load_use same cycle -> flush path only, pc_en=1; halt_req -> HALT, enables 0 until reset.
// - CNT_W=2, 5 stall cycles -> stall_count saturates at 3; async reset mid-STALL -> state=0, count=0.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: drives stage-register enables, IF/ID flush and ID/EX bubble,
// sequencing load-use stalls and branch flushes with a small FSM and counting lost cycles.
module pipeline_hazard_controller #(
   parameter int REG_ADDR_W     = 5,
   parameter int LOAD_STALL_CYC = 1,
   parameter int FLUSH_CYC      = 2,
   parameter int CNT_W          = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_use_rs1,
   input  logic                  id_use_rs2,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_mem_read,
   input  logic                  ex_branch_taken,
   input  logic                  mem_busy,
   input  logic                  halt_req,
   output logic                  pc_en,
   output logic                  en_if_id,
   output logic                  en_id_ex,
   output logic                  en_ex_mem,
   output logic                  en_mem_wb,
   output logic                  flush_if_id,
   output logic                  bubble_id_ex,
   output logic [1:0]            state,
   output logic [CNT_W-1:0]      stall_count
);

   localparam logic [1:0] RUN   = 2'd0;
   localparam logic [1:0] STALL = 2'd1;
   localparam logic [1:0] FLUSH = 2'd2;
   localparam logic [1:0] HALT  = 2'd3;

   localparam int SEQ_MAX = (LOAD_STALL_CYC > FLUSH_CYC) ? LOAD_STALL_CYC : FLUSH_CYC;
   localparam int DC_W    = (SEQ_MAX > 1) ? $clog2(SEQ_MAX + 1) : 1;

   logic [DC_W-1:0] down_cnt;
   logic [DC_W-1:0] next_cnt;
   logic [1:0]      next_state;
   logic            load_use;
   logic            lost_cycle;

   assign load_use = ex_mem_read && (ex_rd != '0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

   // mem_busy freezes everything; otherwise the state decides, and in RUN halt beats branch beats load-use
   always_comb begin
      next_state   = state;
      next_cnt     = down_cnt;
      pc_en        = 1'b1;
      en_if_id     = 1'b1;
      en_id_ex     = 1'b1;
      en_ex_mem    = 1'b1;
      en_mem_wb    = 1'b1;
      flush_if_id  = 1'b0;
      bubble_id_ex = 1'b0;
      if (mem_busy) begin
         pc_en     = 1'b0;
         en_if_id  = 1'b0;
         en_id_ex  = 1'b0;
         en_ex_mem = 1'b0;
         en_mem_wb = 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (halt_req) begin
                  pc_en      = 1'b0;
                  en_if_id   = 1'b0;
                  en_id_ex   = 1'b0;
                  en_ex_mem  = 1'b0;
                  en_mem_wb  = 1'b0;
                  next_state = HALT;
               end else if (ex_branch_taken) begin
                  flush_if_id  = 1'b1;
                  bubble_id_ex = 1'b1;
                  if (FLUSH_CYC > 1) begin
                     next_cnt   = DC_W'(FLUSH_CYC - 1);
                     next_state = FLUSH;
                  end
               end else if (load_use) begin
                  pc_en        = 1'b0;
                  en_if_id     = 1'b0;
                  bubble_id_ex = 1'b1;
                  if (LOAD_STALL_CYC > 1) begin
                     next_cnt   = DC_W'(LOAD_STALL_CYC - 1);
                     next_state = STALL;
                  end
               end
            end
            STALL: begin
               pc_en        = 1'b0;
               en_if_id     = 1'b0;
               bubble_id_ex = 1'b1;
               next_cnt     = down_cnt - DC_W'(1);
               if (down_cnt == DC_W'(1)) next_state = RUN;
            end
            FLUSH: begin
               flush_if_id  = 1'b1;
               bubble_id_ex = 1'b1;
               next_cnt     = down_cnt - DC_W'(1);
               if (down_cnt == DC_W'(1)) next_state = RUN;
            end
            default: begin
               pc_en     = 1'b0;
               en_if_id  = 1'b0;
               en_id_ex  = 1'b0;
               en_ex_mem = 1'b0;
               en_mem_wb = 1'b0;
            end
         endcase
      end
   end

   assign lost_cycle = (!pc_en || flush_if_id || bubble_id_ex) && (state != HALT) && !mem_busy;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= RUN;
         down_cnt <= '0;
      end else begin
         state    <= next_state;
         down_cnt <= next_cnt;
      end
   end

   // Saturating lost-cycle counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_count <= '0;
      end else if (lost_cycle && (stall_count != {CNT_W{1'b1}})) begin
         stall_count <= stall_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed testbench for pipeline_hazard_controller: a default instance plus a CNT_W=2,
// LOAD_STALL_CYC=2 instance for saturation and mid-stall reset.
module tb_pipeline_hazard_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken, mem_busy, halt_req;

   logic        pc_en1, en_if_id1, en_id_ex1, en_ex_mem1, en_mem_wb1, flush1, bubble1;
   logic [1:0]  state1;
   logic [15:0] count1;
   logic        pc_en2, en_if_id2, en_id_ex2, en_ex_mem2, en_mem_wb2, flush2, bubble2;
   logic [1:0]  state2;
   logic [1:0]  count2;
   logic [4:0]  en1, en2;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   assign en1 = {pc_en1, en_if_id1, en_id_ex1, en_ex_mem1, en_mem_wb1};
   assign en2 = {pc_en2, en_if_id2, en_id_ex2, en_ex_mem2, en_mem_wb2};

   pipeline_hazard_controller u1 (
      .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
      .mem_busy(mem_busy), .halt_req(halt_req), .pc_en(pc_en1), .en_if_id(en_if_id1),
      .en_id_ex(en_id_ex1), .en_ex_mem(en_ex_mem1), .en_mem_wb(en_mem_wb1),
      .flush_if_id(flush1), .bubble_id_ex(bubble1), .state(state1), .stall_count(count1)
   );

   pipeline_hazard_controller #(.LOAD_STALL_CYC(2), .FLUSH_CYC(3), .CNT_W(2)) u2 (
      .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
      .mem_busy(mem_busy), .halt_req(halt_req), .pc_en(pc_en2), .en_if_id(en_if_id2),
      .en_id_ex(en_id_ex2), .en_ex_mem(en_ex_mem2), .en_mem_wb(en_mem_wb2),
      .flush_if_id(flush2), .bubble_id_ex(bubble2), .state(state2), .stall_count(count2)
   );

   task automatic idle_inputs();
      id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
      id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
      ex_branch_taken = 1'b0; mem_busy = 1'b0; halt_req = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic set_load_x5();
      ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      #2;
      tests_run++; if (state1 !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_state: got %0d expected 0", state1); end
      tests_run++; if (count1 !== 16'd0) begin tests_failed++; $display("[TB] FAIL reset_count: got %0d expected 0", count1); end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      tests_run++; if (en1 !== 5'b11111) begin tests_failed++; $display("[TB] FAIL idle_en: got %b expected 11111", en1); end
      tests_run++; if ({flush1, bubble1} !== 2'b00) begin tests_failed++; $display("[TB] FAIL idle_flush_bubble: got %b expected 00", {flush1, bubble1}); end
      @(posedge clk); #1;
      tests_run++; if (count1 !== 16'd0) begin tests_failed++; $display("[TB] FAIL idle_count: got %0d expected 0", count1); end
   endtask

   task automatic test_load_use();
      do_reset();
      set_load_x5();
      @(negedge clk);
      tests_run++; if (en1 !== 5'b00111) begin tests_failed++; $display("[TB] FAIL load_use_en: got %b expected 00111", en1); end
      tests_run++; if ({flush1, bubble1} !== 2'b01) begin tests_failed++; $display("[TB] FAIL load_use_fb: got %b expected 01", {flush1, bubble1}); end
      @(posedge clk); #1;
      tests_run++; if (state1 !== 2'd0) begin tests_failed++; $display("[TB] FAIL load_use_state: got %0d expected 0", state1); end
      tests_run++; if (count1 !== 16'd1) begin tests_failed++; $display("[TB] FAIL load_use_count: got %0d expected 1", count1); end
      idle_inputs();
      ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_use_rs2 = 1'b1;
      @(negedge clk);
      tests_run++; if (en1 !== 5'b00111) begin tests_failed++; $display("[TB] FAIL load_use_rs2_en: got %b expected 00111", en1); end
      @(posedge clk); #1;
      idle_inputs();
      ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b0;
      @(negedge clk);
      tests_run++; if (en1 !== 5'b11111) begin tests_failed++; $display("[TB] FAIL unused_rs1_en: got %b expected 11111", en1); end
      @(posedge clk); #1;
      tests_run++; if (count1 !== 16'd2) begin tests_failed++; $display("[TB] FAIL unused_rs1_count: got %0d expected 2", count1); end
   endtask

   task automatic test_rd_zero();
      do_reset();
      ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
      @(negedge clk);
      tests_run++; if (en1 !== 5'b11111) begin tests_failed++; $display("[TB] FAIL rd_zero_en: got %b expected 11111", en1); end
      tests_run++; if (bubble1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL rd_zero_bubble: got %b expected 0", bubble1); end
      @(posedge clk); #1;
      tests_run++; if (count1 !== 16'd0) begin tests_failed++; $display("[TB] FAIL rd_zero_count: got %0d expected 0", count1); end
   endtask

   task automatic test_branch();
      do_reset();
      ex_branch_taken = 1'b1;
      @(negedge clk);
      tests_run++; if ({en1, flush1, bubble1} !== 7'b1111111) begin tests_failed++; $display("[TB] FAIL branch_c1_ctl: got %b expected 1111111", {en1, flush1, bubble1}); end
      @(posedge clk); #1;
      tests_run++; if (state1 !== 2'd2) begin tests_failed++; $display("[TB] FAIL branch_c1_state: got %0d expected 2", state1); end
      ex_branch_taken = 1'b0;
      @(negedge clk);
      tests_run++; if ({en1, flush1, bubble1} !== 7'b1111111) begin tests_failed++; $display("[TB] FAIL branch_c2_ctl: got %b expected 1111111", {en1, flush1, bubble1}); end
      @(posedge clk); #1;
      tests_run++; if (state1 !== 2'd0) begin tests_failed++; $display("[TB] FAIL branch_c2_state: got %0d expected 0", state1); end
      tests_run++; if (count1 !== 16'd2) begin tests_failed++; $display("[TB] FAIL branch_count: got %0d expected 2", count1); end
      @(negedge clk);
      tests_run++; if ({flush1, bubble1} !== 2'b00) begin tests_failed++; $display("[TB] FAIL branch_after_fb: got %b expected 00", {flush1, bubble1}); end
   endtask

   task automatic test_mem_busy_flush();
      do_reset();
      ex_branch_taken = 1'b1;
      @(posedge clk); #1;
      ex_branch_taken = 1'b0;
      mem_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests_run++; if ({en1, flush1, bubble1} !== 7'b0000000) begin tests_failed++; $display("[TB] FAIL busy_ctl[%0d]: got %b expected 0000000", i, {en1, flush1, bubble1}); end
         @(posedge clk); #1;
         tests_run++; if ({state1, count1} !== {2'd2, 16'd1}) begin tests_failed++; $display("[TB] FAIL busy_hold[%0d]: got state %0d count %0d expected state 2 count 1", i, state1, count1); end
      end
      mem_busy = 1'b0;
      @(negedge clk);
      tests_run++; if ({flush1, bubble1} !== 2'b11) begin tests_failed++; $display("[TB] FAIL busy_resume_fb: got %b expected 11", {flush1, bubble1}); end
      @(posedge clk); #1;
      tests_run++; if ({state1, count1} !== {2'd0, 16'd2}) begin tests_failed++; $display("[TB] FAIL busy_resume_end: got state %0d count %0d expected state 0 count 2", state1, count1); end
   endtask

   task automatic test_branch_and_load();
      do_reset();
      set_load_x5();
      ex_branch_taken = 1'b1;
      @(negedge clk);
      tests_run++; if ({en1, flush1, bubble1} !== 7'b1111111) begin tests_failed++; $display("[TB] FAIL branch_load_ctl: got %b expected 1111111", {en1, flush1, bubble1}); end
      @(posedge clk); #1;
      tests_run++; if (state1 !== 2'd2) begin tests_failed++; $display("[TB] FAIL branch_load_state: got %0d expected 2", state1); end
      ex_branch_taken = 1'b0;
      @(negedge clk);
      tests_run++; if (pc_en1 !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush_ignores_load_pc: got %b expected 1", pc_en1); end
      @(posedge clk); #1;
   endtask

   task automatic test_halt();
      do_reset();
      halt_req = 1'b1;
      ex_branch_taken = 1'b1;
      @(negedge clk);
      tests_run++; if ({en1, flush1, bubble1} !== 7'b0000000) begin tests_failed++; $display("[TB] FAIL halt_req_ctl: got %b expected 0000000", {en1, flush1, bubble1}); end
      @(posedge clk); #1;
      tests_run++; if ({state1, count1} !== {2'd3, 16'd1}) begin tests_failed++; $display("[TB] FAIL halt_entry: got state %0d count %0d expected state 3 count 1", state1, count1); end
      halt_req = 1'b0;
      set_load_x5();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         tests_run++; if ({en1, flush1, bubble1} !== 7'b0000000) begin tests_failed++; $display("[TB] FAIL halt_ctl[%0d]: got %b expected 0000000", i, {en1, flush1, bubble1}); end
         @(posedge clk); #1;
         tests_run++; if ({state1, count1} !== {2'd3, 16'd1}) begin tests_failed++; $display("[TB] FAIL halt_hold[%0d]: got state %0d count %0d expected state 3 count 1", i, state1, count1); end
      end
      do_reset();
      tests_run++; if (state1 !== 2'd0) begin tests_failed++; $display("[TB] FAIL halt_reset_state: got %0d expected 0", state1); end
   endtask

   task automatic test_saturation();
      logic [1:0] exp_state [5];
      logic [1:0] exp_count [5];
      exp_state = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
      exp_count = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      do_reset();
      set_load_x5();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tests_run++; if (en2 !== 5'b00111) begin tests_failed++; $display("[TB] FAIL sat_en[%0d]: got %b expected 00111", i, en2); end
         @(posedge clk); #1;
         tests_run++; if ({state2, count2} !== {exp_state[i], exp_count[i]}) begin tests_failed++; $display("[TB] FAIL sat_step[%0d]: got state %0d count %0d expected state %0d count %0d", i, state2, count2, exp_state[i], exp_count[i]); end
      end
      idle_inputs();
      @(negedge clk);
      tests_run++; if ({en2, bubble2} !== 6'b001111) begin tests_failed++; $display("[TB] FAIL stall_ignores_inputs: got %b expected 001111", {en2, bubble2}); end
      #2;
      reset = 1'b0;
      #1;
      tests_run++; if ({state2, count2} !== {2'd0, 2'd0}) begin tests_failed++; $display("[TB] FAIL async_reset_stall: got state %0d count %0d expected state 0 count 0", state2, count2); end
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_rd_zero();
      test_branch();
      test_mem_busy_flush();
      test_branch_and_load();
      test_halt();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
